// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, tracks one in-flight ROM read
// and buffers returned instructions in a 2-entry skid FIFO toward decode.
module fetch_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  logic [31:0] pc_q;
  logic        infl_q;
  logic [31:0] infl_pc_q;
  logic [1:0]  count_q;
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  logic [31:0] redir_aligned;

  assign redir_aligned = {redirect_pc[31:2], 2'b00};
  assign out_valid     = (count_q != 2'd0);
  assign pop           = out_valid & out_ready;
  assign push          = infl_q & ~redirect_valid;

  // Credit: entries held plus the read in flight, less what leaves this cycle.
  assign occ   = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue = ~rst & ~halt & (occ < DEPTH);

  assign rom_addr  = redirect_valid ? redirect_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
    end else if (redirect_valid) begin
      // Flush buffered entries and the stale response; restart at the target.
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      infl_pc_q <= redir_aligned;
      infl_q    <= ~halt;
      pc_q      <= halt ? redir_aligned : redir_aligned + 32'd4;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_pc_q <= pc_q;
        pc_q      <= pc_q + 32'd4;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc_q[wr_ptr_q]    <= infl_pc_q;
      fifo_instr_q[wr_ptr_q] <= rom_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop)
      assert ({1'b0, count_q} < DEPTH)
        else $error("fetch_ctrl skid FIFO overflow");
  end

endmodule
